// File: rtl/uart_cmd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl_pkg
// Description : Shared definitions for the UART command controller: command
//               codes, FSM state encoding and the default PING reply byte.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_ctrl_pkg;

    localparam logic [7:0] CMD_SEND_WORD      = 8'h01;
    localparam logic [7:0] CMD_PING           = 8'h02;
    localparam logic [7:0] PING_REPLY_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        LOAD      = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_word_serializer
// Description : Shift register and byte counter for the outgoing word. A
//               load captures a whole word plus the index of its last byte;
//               each shift moves the next byte into the low position.
// Ports       : clk, reset      - clock, async active-high reset
//               load, load_data - capture a new word (byte 0 sent first)
//               load_last       - index of the last byte of that word
//               shift           - advance to the next byte
//               next_low        - low byte as it will be after this edge
//               last            - current byte is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module uart_word_serializer
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int CNT_W      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [8*WORD_BYTES-1:0] load_data,
    input  logic [CNT_W-1:0]        load_last,
    input  logic                    shift,
    output logic [7:0]              next_low,
    output logic                    last
);

    logic [8*WORD_BYTES-1:0] r_shift_reg;
    logic [CNT_W-1:0]        r_byte_cnt;
    logic [CNT_W-1:0]        r_last_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift_reg <= '0;
            r_byte_cnt  <= '0;
            r_last_idx  <= '0;
        end else if (load) begin
            r_shift_reg <= load_data;
            r_byte_cnt  <= '0;
            r_last_idx  <= load_last;
        end else if (shift) begin
            r_shift_reg <= r_shift_reg >> 8;
            r_byte_cnt  <= r_byte_cnt + CNT_W'(1);
        end
    end

    // Look-ahead byte lets the controller register tx_data on the same edge
    // that loads or shifts this register, so tx_data is valid with tx_start.
    assign next_low = load  ? load_data[7:0]
                    : shift ? 8'(r_shift_reg >> 8)
                    :         r_shift_reg[7:0];

    assign last = (r_byte_cnt == r_last_idx);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Command controller between a UART RX FIFO and a UART
//               transmitter. Pops one command byte, then either sends a word
//               (LSB first), replies to PING, or flags an unknown command.
//               Every transmitted byte waits for tx_done, bounded by a
//               timeout. All outputs are registered.
// Ports       : clk, reset               - clock, async active-high reset
//               rx_available, rx_data    - RX FIFO status and head byte
//               rx_read                  - one-cycle FIFO pop
//               tx_data, tx_start        - byte and start pulse to the TX
//               tx_done                  - end-of-byte pulse from the TX
//               word_in, word_capture    - reported word and its latch pulse
//               busy                     - controller not in IDLE
//               cmd_error, tx_timeout    - error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int         WORD_BYTES = 4,
    parameter int         TX_TIMEOUT = 200000,
    parameter logic [7:0] PING_REPLY = PING_REPLY_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_available,
    input  logic [7:0]              rx_data,
    output logic                    rx_read,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_done,
    input  logic [8*WORD_BYTES-1:0] word_in,
    output logic                    word_capture,
    output logic                    busy,
    output logic                    cmd_error,
    output logic                    tx_timeout
);

    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TO_W  = $clog2(TX_TIMEOUT);

    localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(WORD_BYTES - 1);
    // Abort is decided on the edge where the counter steps to TX_TIMEOUT-1,
    // which puts the tx_timeout pulse exactly TX_TIMEOUT cycles after tx_start.
    localparam logic [TO_W-1:0]  c_TO_HIT   = TO_W'(TX_TIMEOUT - 2);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [7:0]              r_cmd;
    logic [TO_W-1:0]         r_to_cnt;

    logic                    r_rx_read;
    logic                    r_tx_start;
    logic [7:0]              r_tx_data;
    logic                    r_word_capture;
    logic                    r_busy;
    logic                    r_cmd_error;
    logic                    r_tx_timeout;

    logic                    w_ser_load;
    logic                    w_ser_shift;
    logic [8*WORD_BYTES-1:0] w_load_data;
    logic [CNT_W-1:0]        w_load_last;
    logic [7:0]              w_next_low;
    logic                    w_ser_last;
    logic                    w_word_capture;
    logic                    w_cmd_error;
    logic                    w_timeout;

    uart_word_serializer #(
        .WORD_BYTES (WORD_BYTES),
        .CNT_W      (CNT_W)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (w_ser_load),
        .load_data (w_load_data),
        .load_last (w_load_last),
        .shift     (w_ser_shift),
        .next_low  (w_next_low),
        .last      (w_ser_last)
    );

    // ------------------------------------------------------------------
    // Next-state and per-cycle control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_ser_load     = 1'b0;
        w_ser_shift    = 1'b0;
        w_load_data    = '0;
        w_load_last    = '0;
        w_word_capture = 1'b0;
        w_cmd_error    = 1'b0;
        w_timeout      = 1'b0;

        case (r_state)
            IDLE: begin
                if (rx_available) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                w_next_state = DECODE;
            end
            DECODE: begin
                if (r_cmd == CMD_SEND_WORD) begin
                    w_ser_load     = 1'b1;
                    w_load_data    = word_in;
                    w_load_last    = c_LAST_IDX;
                    w_word_capture = 1'b1;
                    w_next_state   = LOAD;
                end else if (r_cmd == CMD_PING) begin
                    w_ser_load       = 1'b1;
                    w_load_data[7:0] = PING_REPLY;
                    w_load_last      = '0;
                    w_next_state     = LOAD;
                end else begin
                    w_cmd_error  = 1'b1;
                    w_next_state = IDLE;
                end
            end
            LOAD: begin
                // tx_done is deliberately not looked at here
                w_next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    if (w_ser_last) begin
                        w_next_state = IDLE;
                    end else begin
                        w_ser_shift  = 1'b1;
                        w_next_state = LOAD;
                    end
                end else if (r_to_cnt == c_TO_HIT) begin
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs (decoded from the next state so each
    // pulse lines up with the state it belongs to)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_cmd          <= 8'h00;
            r_to_cnt       <= '0;
            r_rx_read      <= 1'b0;
            r_tx_start     <= 1'b0;
            r_tx_data      <= 8'h00;
            r_word_capture <= 1'b0;
            r_busy         <= 1'b0;
            r_cmd_error    <= 1'b0;
            r_tx_timeout   <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_rx_read      <= (w_next_state == FETCH);
            r_tx_start     <= (w_next_state == LOAD);
            r_busy         <= (w_next_state != IDLE);
            r_word_capture <= w_word_capture;
            r_cmd_error    <= w_cmd_error;
            r_tx_timeout   <= w_timeout;

            if (r_state == FETCH) begin
                r_cmd <= rx_data;
            end

            if (w_next_state == LOAD) begin
                r_tx_data <= w_next_low;
            end

            if (r_state == LOAD) begin
                r_to_cnt <= '0;
            end else if (r_state == WAIT_DONE) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
        end
    end

    assign rx_read      = r_rx_read;
    assign tx_start     = r_tx_start;
    assign tx_data      = r_tx_data;
    assign word_capture = r_word_capture;
    assign busy         = r_busy;
    assign cmd_error    = r_cmd_error;
    assign tx_timeout   = r_tx_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Self-checking bench for uart_cmd_ctrl. Models the RX FIFO and
//               the UART transmitter, builds the expected byte stream from
//               the command list, and compares counts, latencies and bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int WB = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_available;
    logic [7:0]  rx_data;
    logic        rx_read;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done;
    logic [31:0] word_in;
    logic        word_capture;
    logic        busy;
    logic        cmd_error;
    logic        tx_timeout;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(
        .WORD_BYTES (WB),
        .TX_TIMEOUT (TO),
        .PING_REPLY (8'hA5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_available (rx_available),
        .rx_data      (rx_data),
        .rx_read      (rx_read),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .word_in      (word_in),
        .word_capture (word_capture),
        .busy         (busy),
        .cmd_error    (cmd_error),
        .tx_timeout   (tx_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // environment model state
    int          cyc = 0;
    logic [7:0]  rx_q[$];
    logic        prev_rx_read = 1'b0;
    bit          tx_pending = 0;
    bit          tx_mute = 0;
    int          tx_cnt_down = 0;
    logic [7:0]  tx_log[$];
    int          n_tx_start = 0, n_rx_read = 0, n_cmd_err = 0;
    int          n_capture = 0, n_timeout = 0, n_overlap = 0;
    int          last_start_cyc = 0, last_read_cyc = 0;
    int          last_err_cyc = 0, last_timeout_cyc = 0;
    logic [31:0] word_list[$];
    int          word_idx = 0;
    logic [7:0]  cmd_list[$];
    int          gap_max = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh_rx();
        rx_available = (rx_q.size() != 0);
        rx_data      = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
        refresh_rx();
    endtask

    // One clock: observe the DUT just after the edge and advance the models.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        // FIFO pops on the edge that ends the cycle rx_read was high
        if (prev_rx_read && rx_q.size() != 0) void'(rx_q.pop_front());
        prev_rx_read = rx_read;
        if (rx_read) begin
            n_rx_read++;
            last_read_cyc = cyc;
        end
        if (cmd_error) begin
            n_cmd_err++;
            last_err_cyc = cyc;
        end
        if (tx_timeout) begin
            n_timeout++;
            last_timeout_cyc = cyc;
            tx_pending = 0;
        end
        if (word_capture) begin
            n_capture++;
            word_idx++;
            // new value right after capture must not reach bytes in flight
            word_in = (word_idx < word_list.size()) ? word_list[word_idx] : $urandom;
        end
        tx_done = 1'b0;
        if (tx_pending && !tx_mute) begin
            tx_cnt_down--;
            if (tx_cnt_down == 0) begin
                tx_done    = 1'b1;
                tx_pending = 0;
            end
        end
        if (tx_start) begin
            if (tx_pending) n_overlap++;
            tx_log.push_back(tx_data);
            n_tx_start++;
            last_start_cyc = cyc;
            tx_pending  = 1;
            tx_cnt_down = $urandom_range(1, 12);
            // stray pulse during the start cycle, which must be ignored
            if ($urandom_range(0, 2) == 0) tx_done = 1'b1;
        end
        refresh_rx();
    endtask

    task automatic drain(input string tag, input int budget);
        int k = 0;
        while (!(rx_q.size() == 0 && !busy && !tx_pending) && k < budget) begin
            step();
            k++;
        end
        check({tag, "_drain"}, 64'(rx_q.size() == 0 && !busy && !tx_pending), 64'd1);
    endtask

    // Push cmd_list (words taken from word_list) and compare the outcome
    // with the stream the command rules predict.
    task automatic run_batch(input string tag);
        logic [7:0]  exp_q[$];
        logic [31:0] w;
        int exp_err = 0;
        int exp_cap = 0;
        int k = 0;
        int b_start = n_tx_start;
        int b_read  = n_rx_read;
        int b_err   = n_cmd_err;
        int b_cap   = n_capture;
        int b_ovl   = n_overlap;
        foreach (cmd_list[i]) begin
            if (cmd_list[i] == 8'h01) begin
                w = word_list[k];
                k++;
                exp_cap++;
                for (int j = 0; j < WB; j++) exp_q.push_back(w[8*j +: 8]);
            end else if (cmd_list[i] == 8'h02) begin
                exp_q.push_back(8'hA5);
            end else begin
                exp_err++;
            end
        end
        tx_log.delete();
        word_idx = 0;
        word_in  = (word_list.size() != 0) ? word_list[0] : $urandom;
        foreach (cmd_list[i]) begin
            push(cmd_list[i]);
            repeat ($urandom_range(0, gap_max)) step();
        end
        drain(tag, 3000);
        step();
        check({tag, "_reads"},   64'(n_rx_read - b_read),   64'(cmd_list.size()));
        check({tag, "_errors"},  64'(n_cmd_err - b_err),    64'(exp_err));
        check({tag, "_capture"}, 64'(n_capture - b_cap),    64'(exp_cap));
        check({tag, "_starts"},  64'(n_tx_start - b_start), 64'(exp_q.size()));
        check({tag, "_overlap"}, 64'(n_overlap - b_ovl),    64'd0);
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
            check({tag, "_byte"}, 64'(tx_log[i]), 64'(exp_q[i]));
    endtask

    initial begin
        int c;
        int k;
        int b_start, b_read, b_err, b_to;
        logic [7:0] v;

        reset        = 1'b1;
        rx_available = 1'b0;
        rx_data      = 8'h00;
        tx_done      = 1'b0;
        word_in      = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_read",   64'(rx_read),      64'd0);
        check("rst_tx_start",  64'(tx_start),     64'd0);
        check("rst_tx_data",   64'(tx_data),      64'd0);
        check("rst_busy",      64'(busy),         64'd0);
        check("rst_capture",   64'(word_capture), 64'd0);
        check("rst_cmd_error", 64'(cmd_error),    64'd0);
        check("rst_timeout",   64'(tx_timeout),   64'd0);
        reset = 1'b0;
        step();
        step();

        // PING with latency measurement
        b_start = n_tx_start;
        tx_log.delete();
        push(8'h02);
        c = cyc;
        k = 0;
        while (n_tx_start == b_start && k < 20) begin step(); k++; end
        check("ping_read_lat",  64'(last_read_cyc - c),  64'd1);
        check("ping_start_lat", 64'(last_start_cyc - c), 64'd3);
        check("ping_data",      64'(tx_data),            64'hA5);
        drain("ping", 200);
        check("ping_starts", 64'(n_tx_start - b_start), 64'd1);
        check("ping_busy",   64'(busy),                 64'd0);

        // Unknown command
        b_start = n_tx_start; b_read = n_rx_read; b_err = n_cmd_err;
        push(8'h7F);
        c = cyc;
        repeat (6) step();
        check("unk_err",     64'(n_cmd_err - b_err),    64'd1);
        check("unk_err_lat", 64'(last_err_cyc - c),     64'd3);
        check("unk_reads",   64'(n_rx_read - b_read),   64'd1);
        check("unk_starts",  64'(n_tx_start - b_start), 64'd0);
        check("unk_busy",    64'(busy),                 64'd0);

        // SEND_WORD with a known word
        cmd_list = '{8'h01};
        word_list = '{32'hDEADBEEF};
        gap_max = 0;
        run_batch("word");

        // Two commands queued together
        cmd_list = '{8'h01, 8'h02};
        word_list = '{$urandom};
        run_batch("queued");

        // Random command mixes, some arriving while busy
        gap_max = 30;
        for (int b = 0; b < 6; b++) begin
            cmd_list.delete();
            word_list.delete();
            for (int i = 0; i < $urandom_range(3, 7); i++) begin
                case ($urandom_range(0, 4))
                    0, 1: begin cmd_list.push_back(8'h01); word_list.push_back($urandom); end
                    2, 3: cmd_list.push_back(8'h02);
                    default: begin
                        v = 8'($urandom_range(0, 255));
                        while (v == 8'h01 || v == 8'h02) v = 8'($urandom_range(0, 255));
                        cmd_list.push_back(v);
                    end
                endcase
            end
            run_batch("rand");
        end

        // Transmit timeout: transmitter never answers
        tx_mute = 1;
        b_start = n_tx_start; b_to = n_timeout;
        push(8'h02);
        k = 0;
        while (n_timeout == b_to && k < 100) begin step(); k++; end
        check("to_seen",   64'(n_timeout - b_to),                 64'd1);
        check("to_lat",    64'(last_timeout_cyc - last_start_cyc), 64'(TO));
        check("to_busy",   64'(busy),                             64'd0);
        check("to_starts", 64'(n_tx_start - b_start),             64'd1);
        tx_mute = 0;
        tx_pending = 0;
        gap_max = 0;
        cmd_list = '{8'h02};
        word_list.delete();
        run_batch("after_to");

        // Reset while waiting for byte 2 of a word
        word_list = '{$urandom};
        word_idx = 0;
        word_in = word_list[0];
        tx_log.delete();
        b_start = n_tx_start;
        push(8'h01);
        k = 0;
        while (n_tx_start - b_start < 2 && k < 200) begin step(); k++; end
        tx_mute = 1;
        step();
        step();
        check("mid_busy",  64'(busy), 64'd1);
        check("mid_byte2", 64'((tx_log.size() > 1) ? tx_log[1] : 8'h00), 64'(word_list[0][15:8]));
        reset = 1'b1;
        #1;
        check("mid_rst_busy",  64'(busy),     64'd0);
        check("mid_rst_start", 64'(tx_start), 64'd0);
        check("mid_rst_data",  64'(tx_data),  64'd0);
        check("mid_rst_read",  64'(rx_read),  64'd0);
        step();
        step();
        reset = 1'b0;
        tx_mute = 0;
        tx_pending = 0;
        repeat (30) step();
        check("mid_no_restart", 64'(n_tx_start - b_start), 64'd2);
        check("mid_idle",       64'(busy),                 64'd0);
        cmd_list = '{8'h02};
        word_list.delete();
        run_batch("after_rst");

        check("overlap_total", 64'(n_overlap), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
